// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style requester bundle: one instance per engine feeding the arbiter.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [1:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM port between two requesters.
// Reads are tagged in an in-order ID FIFO so each returned beat reaches its issuer.
//
// state | meaning
// IDLE  | no grant; picks the next owner, the side that was not last wins ties
// G0    | requester 0 drives the controller
// G1    | requester 1 drives the controller
module sdram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  parameter int MAX_HOLD    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  sdram_port_arbiter_if.slave           m0,
  sdram_port_arbiter_if.slave           m1,
  output logic [ADDR_W-1:0]             sdram_address,
  output logic                          sdram_read_n,
  output logic                          sdram_write_n,
  output logic                          sdram_chipselect,
  output logic [1:0]                    sdram_byteenable,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic                          sdram_waitrequest,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_readdatavalid,
  output logic [1:0]                    grant,
  output logic [$clog2(MAX_PENDING):0]  pending,
  output logic                          err_orphan
);
  localparam int PTR_W  = $clog2(MAX_PENDING);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [PTR_W:0]    PEND_FULL = (PTR_W + 1)'(MAX_PENDING);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;

  logic [1:0]             state;
  logic                   last;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [MAX_PENDING-1:0] id_mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  logic              req0, req1;
  logic              granted, sel;
  logic              g_read, g_write, g_req, g_req_other;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [1:0]        g_be;
  logic              pop_ok, fifo_full, head_id;
  logic              rd_go, wr_go, accept, push, g_wait;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign granted = !reset && (state == S_G0 || state == S_G1);
  assign sel     = (state == S_G1);

  assign g_read      = sel ? m1.read       : m0.read;
  assign g_write     = sel ? m1.write      : m0.write;
  assign g_addr      = sel ? m1.address    : m0.address;
  assign g_wdata     = sel ? m1.writedata  : m0.writedata;
  assign g_be        = sel ? m1.byteenable : m0.byteenable;
  assign g_req       = sel ? req1 : req0;
  assign g_req_other = sel ? req0 : req1;

  // A beat popping this cycle frees a slot, so a read may push into a full FIFO
  assign pop_ok    = !reset && sdram_readdatavalid && (pending != '0);
  assign fifo_full = (pending == PEND_FULL) && !pop_ok;
  assign head_id   = id_mem[rd_ptr];

  // Write wins when a requester illegally raises both strobes
  assign rd_go  = granted && g_read && !g_write && !fifo_full;
  assign wr_go  = granted && g_write;
  assign accept = (rd_go || wr_go) && !sdram_waitrequest;
  assign push   = rd_go && !sdram_waitrequest;
  assign g_wait = sdram_waitrequest || (g_read && !g_write && fifo_full);

  assign m0.waitrequest   = !(granted && !sel) || g_wait;
  assign m1.waitrequest   = !(granted && sel) || g_wait;
  assign m0.readdatavalid = pop_ok && !head_id;
  assign m1.readdatavalid = pop_ok && head_id;
  assign m0.readdata      = (pop_ok && !head_id) ? sdram_readdata : '0;
  assign m1.readdata      = (pop_ok && head_id)  ? sdram_readdata : '0;

  assign sdram_address    = granted ? g_addr  : '0;
  assign sdram_writedata  = granted ? g_wdata : '0;
  assign sdram_byteenable = granted ? g_be    : 2'b11;
  assign sdram_read_n     = !rd_go;
  assign sdram_write_n    = !wr_go;
  assign sdram_chipselect = 1'b1;
  assign grant            = {granted && sel, granted && !sel};

  // Grant FSM with round-robin tie break and burst-hold hand-off
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hold_cnt <= '0;
          if (req0 && (!req1 || last)) state <= S_G0;
          else if (req1)               state <= S_G1;
        end
        S_G0, S_G1: begin
          if (!g_req) begin
            state    <= S_IDLE;
            last     <= sel;
            hold_cnt <= '0;
          end else if (accept && hold_cnt == HOLD_LAST && g_req_other) begin
            state    <= sel ? S_G0 : S_G1;
            last     <= sel;
            hold_cnt <= '0;
          end else if (accept && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ID storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

  // FIFO pointers, occupancy and sticky orphan flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (sdram_readdatavalid && pending == '0) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: reads push expected data per requester; a negedge monitor
// pops and compares whenever a requester sees readdatavalid.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int MAXP   = 8;
  localparam int MAXH   = 4;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i0 ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i1 ();

  logic [ADDR_W-1:0] sdram_address;
  logic              sdram_read_n, sdram_write_n, sdram_chipselect;
  logic [1:0]        sdram_byteenable;
  logic [DATA_W-1:0] sdram_writedata;
  logic              sdram_waitrequest = 1'b0;
  logic [DATA_W-1:0] sdram_readdata = '0;
  logic              sdram_readdatavalid = 1'b0;
  logic [1:0]        grant;
  logic [3:0]        pending;
  logic              err_orphan;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .m0(i0), .m1(i1),
    .sdram_address(sdram_address), .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
    .sdram_chipselect(sdram_chipselect), .sdram_byteenable(sdram_byteenable),
    .sdram_writedata(sdram_writedata), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
    .grant(grant), .pending(pending), .err_orphan(err_orphan)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int peak = 0;
  int rdv0_cnt = 0;
  int rdv1_cnt = 0;
  logic ctrl_hold = 1'b0;

  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t        ret_q[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  function automatic logic [15:0] rdata_of(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: fixed read latency, optional withholding of returns
  always @(negedge clk) begin
    if (!sdram_read_n && !sdram_waitrequest)
      ret_q.push_back('{cyc + LAT, rdata_of(sdram_address)});
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!ctrl_hold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      sdram_readdatavalid = 1'b1;
      sdram_readdata      = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      sdram_readdatavalid = 1'b0;
      sdram_readdata      = '0;
    end
  end

  // Monitor: every routed beat must match the head of its requester's queue
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset) begin
      if (int'(pending) > peak) peak = int'(pending);
      if (i0.readdatavalid) begin
        rdv0_cnt++;
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_unexpected_beat: got data %0h expected no beat", i0.readdata);
        end else begin
          e = exp0.pop_front();
          chk("m0_readdata", 32'(i0.readdata), 32'(e));
        end
      end
      if (i1.readdatavalid) begin
        rdv1_cnt++;
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_unexpected_beat: got data %0h expected no beat", i1.readdata);
        end else begin
          e = exp1.pop_front();
          chk("m1_readdata", 32'(i1.readdata), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_m(input int p, input logic rd, input logic wr, input logic [31:0] a, input logic [15:0] d);
    if (p == 0) begin
      i0.read = rd; i0.write = wr; i0.address = a; i0.writedata = d; i0.byteenable = 2'b11;
    end else begin
      i1.read = rd; i1.write = wr; i1.address = a; i1.writedata = d; i1.byteenable = 2'b11;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    exp0.delete();
    exp1.delete();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic issue_reads(input int p, input int n, input logic [31:0] base, output int cycles);
    int i;
    logic w;
    i = 0;
    cycles = 0;
    set_m(p, 1, 0, base, 0);
    while (i < n && cycles < 60) begin
      @(negedge clk);
      cycles++;
      w = (p == 0) ? i0.waitrequest : i1.waitrequest;
      if (!w) begin
        if (p == 0) exp0.push_back(rdata_of(base + 32'(4 * i)));
        else        exp1.push_back(rdata_of(base + 32'(4 * i)));
        i++;
      end
      tick();
      if (i < n) set_m(p, 1, 0, base + 32'(4 * i), 0);
      else       set_m(p, 0, 0, 0, 0);
    end
    if (i < n) begin
      checks++; errors++;
      $display("FAIL issue_reads_timeout: port %0d accepted %0d expected %0d", p, i, n);
      set_m(p, 0, 0, 0, 0);
    end
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0;
    while ((exp0.size() > 0 || exp1.size() > 0) && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp0.size() > 0 || exp1.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d beats outstanding expected 0/0", exp0.size(), exp1.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, acc0, gap, b0, b1;
    logic [31:0] a0;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);

    // Reset values
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_err_orphan", 32'(err_orphan), 0);
    chk("rst_m0_wait", 32'(i0.waitrequest), 1);
    chk("rst_m1_wait", 32'(i1.waitrequest), 1);
    chk("rst_m0_rdv", 32'(i0.readdatavalid), 0);
    chk("rst_m1_rdv", 32'(i1.readdatavalid), 0);
    chk("rst_m0_rdata", 32'(i0.readdata), 0);
    chk("rst_read_n", 32'(sdram_read_n), 1);
    chk("rst_write_n", 32'(sdram_write_n), 1);
    chk("rst_address", sdram_address, 0);
    chk("rst_byteenable", 32'(sdram_byteenable), 3);
    chk("rst_writedata", 32'(sdram_writedata), 0);
    chk("rst_chipselect", 32'(sdram_chipselect), 1);
    do_reset(2);

    // Single-requester reads: 1 grant cycle + 4 back-to-back accepts
    peak = 0;
    issue_reads(0, 4, 32'h100, n);
    chk("s1_accept_cycles", n, 5);
    drain(20);
    chk("s1_peak_pending", peak, 3);
    chk("s1_m0_beats", rdv0_cnt, 4);
    chk("s1_m1_beats", rdv1_cnt, 0);
    @(negedge clk);
    chk("s1_pending_end", 32'(pending), 0);

    // Round-robin with IDLE bubble and a controller stall
    tick();
    do_reset(2);
    set_m(0, 0, 1, 32'h200, 16'h1111);
    set_m(1, 0, 1, 32'h300, 16'h3333);
    @(negedge clk);
    chk("s2_idle_grant", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("s2_grant_g0", 32'(grant), 1);
    chk("s2_write_n", 32'(sdram_write_n), 0);
    chk("s2_address", sdram_address, 32'h200);
    chk("s2_wdata0", 32'(sdram_writedata), 32'h1111);
    chk("s2_m0_wait", 32'(i0.waitrequest), 0);
    chk("s2_m1_wait", 32'(i1.waitrequest), 1);
    tick();
    set_m(0, 0, 1, 32'h204, 16'h2222);
    sdram_waitrequest = 1'b1;
    @(negedge clk);
    chk("s2_stall_wait", 32'(i0.waitrequest), 1);
    tick();
    sdram_waitrequest = 1'b0;
    @(negedge clk);
    chk("s2_after_stall_wait", 32'(i0.waitrequest), 0);
    chk("s2_wdata1", 32'(sdram_writedata), 32'h2222);
    tick();
    set_m(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s2_release_grant", 32'(grant), 1);
    chk("s2_release_write_n", 32'(sdram_write_n), 1);
    tick();
    @(negedge clk);
    chk("s2_bubble_grant", 32'(grant), 0);
    chk("s2_bubble_m1_wait", 32'(i1.waitrequest), 1);
    tick();
    @(negedge clk);
    chk("s2_grant_g1", 32'(grant), 2);
    chk("s2_m1_address", sdram_address, 32'h300);
    chk("s2_m1_wdata", 32'(sdram_writedata), 32'h3333);
    chk("s2_m1_wait", 32'(i1.waitrequest), 0);
    tick();
    set_m(1, 0, 0, 0, 0);
    tick();
    set_m(0, 0, 1, 32'h208, 16'h4444);
    set_m(1, 0, 1, 32'h308, 16'h5555);
    @(negedge clk);
    chk("s2_idle_again", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("s2_rr_g0_again", 32'(grant), 1);
    tick();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);

    // Hold limit: m0 gets MAX_HOLD accepts then direct hand-off to m1
    do_reset(2);
    a0 = 32'h400;
    acc0 = 0;
    gap = 0;
    set_m(0, 1, 0, a0, 0);
    set_m(1, 1, 0, 32'h500, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (grant == 2'b10) break;
      if (acc0 > 0 && grant != 2'b01) gap++;
      if (!i0.waitrequest) begin
        exp0.push_back(rdata_of(a0));
        acc0++;
        a0 += 32'd4;
      end
      tick();
      i0.address = a0;
    end
    chk("s3_m0_accepts", acc0, 4);
    chk("s3_grant_g1", 32'(grant), 2);
    chk("s3_bubbles", gap, 0);
    chk("s3_m1_wait", 32'(i1.waitrequest), 0);
    if (!i1.waitrequest) exp1.push_back(rdata_of(32'h500));
    tick();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    drain(30);

    // Full FIFO: 9th read stalls, then is accepted on the first return beat
    do_reset(2);
    ctrl_hold = 1'b1;
    issue_reads(0, 8, 32'h600, n);
    chk("s4_fill_cycles", n, 9);
    set_m(0, 1, 0, 32'h620, 0);
    @(negedge clk);
    chk("s4_pending_full", 32'(pending), 8);
    chk("s4_m0_wait_full", 32'(i0.waitrequest), 1);
    chk("s4_read_n_full", 32'(sdram_read_n), 1);
    tick();
    @(negedge clk);
    chk("s4_m0_wait_still", 32'(i0.waitrequest), 1);
    ctrl_hold = 1'b0;
    tick();
    @(negedge clk);
    chk("s4_rdv_first", 32'(i0.readdatavalid), 1);
    chk("s4_m0_wait_pop", 32'(i0.waitrequest), 0);
    chk("s4_read_n_pop", 32'(sdram_read_n), 0);
    exp0.push_back(rdata_of(32'h620));
    tick();
    set_m(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s4_pending_stays", 32'(pending), 8);
    drain(40);

    // Interleaved returns after the grant moves from m0 to m1
    do_reset(2);
    ctrl_hold = 1'b1;
    b0 = rdv0_cnt;
    b1 = rdv1_cnt;
    issue_reads(0, 2, 32'h700, n);
    issue_reads(1, 2, 32'h800, n);
    @(negedge clk);
    chk("s5_pending", 32'(pending), 4);
    ctrl_hold = 1'b0;
    drain(30);
    chk("s5_m0_beats", rdv0_cnt - b0, 2);
    chk("s5_m1_beats", rdv1_cnt - b1, 2);

    // Reset with reads in flight; late beats become orphans
    do_reset(2);
    ctrl_hold = 1'b1;
    issue_reads(0, 3, 32'h900, n);
    @(negedge clk);
    chk("s6_pending_before", 32'(pending), 3);
    tick();
    reset = 1'b1;
    exp0.delete();
    tick();
    @(negedge clk);
    chk("s6_rst_pending", 32'(pending), 0);
    chk("s6_rst_grant", 32'(grant), 0);
    chk("s6_rst_err", 32'(err_orphan), 0);
    tick();
    reset = 1'b0;
    b0 = rdv0_cnt;
    @(negedge clk);
    ctrl_hold = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("s6_err_set", 32'(err_orphan), 1);
    chk("s6_pending_zero", 32'(pending), 0);
    chk("s6_no_beats", rdv0_cnt - b0, 0);
    repeat (5) tick();
    @(negedge clk);
    chk("s6_err_sticky", 32'(err_orphan), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("s6_err_cleared", 32'(err_orphan), 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester arbiter that shares the single SDRAM Avalon-MM master port between the image/weight fetch engine (requester 0) and the writeback/auxiliary engine (requester 1). Grants are round-robin with a burst-hold limit. An in-order ID FIFO routes each `readdatavalid` beat back to the requester that issued the read. It sits between the layer-compute masters and the SDRAM controller, replacing direct master-to-controller wiring.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 16, signed data width
- `MAX_PENDING`, 8, outstanding-read capacity; power of 2, ≥2
- `MAX_HOLD`, 64, accepted commands before forced hand-off when the other side is requesting

Ports:
- `clk` in 1 — single clock; all logic rising-edge
- `reset` in 1 — synchronous, active-high
- `mN_address` in ADDR_W — requester N address (N = 0, 1)
- `mN_read` in 1 — active-high read request
- `mN_write` in 1 — active-high write request
- `mN_writedata` in DATA_W — write data
- `mN_byteenable` in 2 — byte enables
- `mN_waitrequest` out 1 — stall; command not accepted this cycle
- `mN_readdata` out DATA_W — routed read data
- `mN_readdatavalid` out 1 — routed data-valid strobe
- `sdram_address` out ADDR_W — to controller
- `sdram_read_n`, `sdram_write_n` out 1 — active-low strobes
- `sdram_chipselect` out 1 — held 1
- `sdram_byteenable` out 2 — byte enables
- `sdram_writedata` out DATA_W — write data
- `sdram_waitrequest` in 1 — controller stall
- `sdram_readdata` in DATA_W — read data
- `sdram_readdatavalid` in 1 — data-valid
- `grant` out 2 — one-hot current grant; 00 = none
- `pending` out $clog2(MAX_PENDING)+1 — reads in flight
- `err_orphan` out 1 — sticky: a `readdatavalid` arrived with the FIFO empty

## Operation
- FSM states: IDLE, G0, G1. Reset enters IDLE with `last` = 1, so requester 0 wins first.
- IDLE: if any `mN_read|mN_write` is asserted, go to G0 or G1 next cycle. If both request, the winner is the one that is not `last`.
- GN: SDRAM outputs are driven combinationally from requester N.
  - `sdram_read_n` = !(mN_read & !fifo_full).
  - `sdram_write_n` = !mN_write.
- Accept (GN): (mN_read & !fifo_full | mN_write) & !sdram_waitrequest.
  - Read accept pushes ID N into the FIFO.
  - Simultaneous `mN_read` and `mN_write`: treated as a protocol error. Write has priority; the read is stalled.
- `mN_waitrequest`:
  - Non-granted requester: held at 1.
  - Granted requester: `sdram_waitrequest` | (mN_read & fifo_full).
- Hold counter: cleared on every grant change; increments on each accept.
- Release from GN (registered, takes effect next cycle):
  - (a) GN has no request this cycle → IDLE, `last` = N.
  - (b) hold counter = MAX_HOLD−1, an accept occurs, and the other requester is requesting → direct to G(other), `last` = N.
- Read return: each `sdram_readdatavalid` pops the FIFO head. It asserts `m{head}_readdatavalid` with `readdata` the same cycle (combinational); the other requester's `readdatavalid` is 0.
  - Returns are independent of current grant.
  - Empty FIFO: the beat is dropped and `err_orphan` is set (cleared only by reset).
- Simultaneous push and pop: `pending` unchanged; legal even when full, but a push at full is blocked by the accept rule.
- Idle outputs (IDLE state or reset): `sdram_read_n` = 1, `sdram_write_n` = 1, `sdram_address` = 0, `sdram_writedata` = 0, `sdram_byteenable` = 2'b11, `sdram_chipselect` = 1.

## Timing
- Reset values:
  - `grant` = 00, `pending` = 0, `err_orphan` = 0.
  - Both `mN_waitrequest` = 1; both `mN_readdatavalid` = 0; both `mN_readdata` = 0.
  - SDRAM outputs at their idle values.
  - FIFO pointers and hold counter cleared.
- Reset mid-operation: in-flight reads are forgotten. Late `readdatavalid` beats after reset set `err_orphan`; the system must drain the controller before reset.
- Grant latency: a request seen in IDLE at cycle t is granted at t+1; earliest accept is t+1.
- Back-to-back accepts: one per cycle while granted and unstalled.
- Hand-off:
  - Forced switch (b): zero bubble cycles.
  - Release via IDLE: one bubble cycle.
- Read data path: zero added latency, combinational from `sdram_readdata` and `sdram_readdatavalid`.
- `pending`: registered; reflects pushes and pops of the previous cycle.

## Test plan
- **Single-requester reads.** Reset, then m0 reads 4 addresses, controller returning each 3 cycles later with no waitrequest → `grant` = 01 at cycle 1. Expect 4 accepts on consecutive cycles, 4 `m0_readdatavalid` with matching data, `pending` peaking at 3, `m1_readdatavalid` never 1.
- **Round-robin.** m0 and m1 both request from IDLE → G0 first. m0 drops after 2 writes → IDLE, then G1 after 1 bubble. Then both request again → G0.
- **Hold limit.** MAX_HOLD = 4; m0 streams 10 reads while m1 is requesting → exactly 4 m0 accepts, then `grant` = 10 the next cycle with no bubble.
- **Full FIFO.** MAX_PENDING = 8, controller withholds data → 9th read stalls with `m0_waitrequest` = 1 and `sdram_read_n` = 1. On the first return beat, the stalled read is accepted in that same cycle; `pending` stays 8.
- **Interleaved returns.** m0 issues 2 reads, then m1 issues 2 reads; data D0–D3 return after the grant switch → D0 and D1 go to m0, D2 and D3 go to m1, in order.
- **Orphan and reset.** Reset asserted with 3 reads pending → `pending` = 0, `grant` = 00, `err_orphan` = 0. Next `readdatavalid` → dropped, `err_orphan` = 1 and stays 1 until the next reset.
